// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: turns M-stage load/store control into a
// req/ready handshake and stalls the pipeline until the access completes.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_read_m_i,
  input  logic                  mem_write_m_i,
  input  logic [ADDR_WIDTH-1:0] alu_out_m_i,
  input  logic [DATA_WIDTH-1:0] write_data_m_i,
  output logic                  req_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] read_data_m_o,
  output logic                  stall_o,
  output logic                  addr_err_o,
  output logic                  bus_err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A zero TIMEOUT still needs a one-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : CNT_W'(0);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             access;
  logic             aligned;
  logic             timeout_hit;

  assign access      = mem_read_m_i | mem_write_m_i;
  assign aligned     = (alu_out_m_i[1:0] == 2'b00);
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  assign req_o = (state == S_WAIT);

  // Gated by reset so the pipeline is released the moment reset asserts.
  assign stall_o = rst_ni &
                   (((state == S_IDLE) & access & aligned) | (state == S_WAIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      we_o          <= 1'b0;
      addr_o        <= '0;
      wdata_o       <= '0;
      read_data_m_o <= '0;
      addr_err_o    <= 1'b0;
      bus_err_o     <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (aligned) begin
              addr_o  <= {alu_out_m_i[ADDR_WIDTH-1:2], 2'b00};
              wdata_o <= write_data_m_i;
              we_o    <= mem_write_m_i;
              state   <= S_WAIT;
            end else begin
              addr_err_o <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // ready_i takes priority over a timeout landing in the same cycle.
          if (ready_i) begin
            if (!we_o) begin
              read_data_m_o <= rdata_i;
            end
            we_o  <= 1'b0;
            state <= S_DONE;
          end else if (timeout_hit) begin
            read_data_m_o <= '0;
            bus_err_o     <= 1'b1;
            we_o          <= 1'b0;
            state         <= S_DONE;
          end else if (TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          wait_cnt <= '0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table driven into the DUT,
// completions scored by a negedge monitor against a queue of expectations.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_addr_err;
    logic        exp_bus_err;
    logic [31:0] exp_read_data;
    int          exp_req;
    int          exp_stall;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] alu_out;
  logic [31:0] write_data;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] read_data;
  logic        stall;
  logic        addr_err;
  logic        bus_err;

  int   tests_run = 0;
  int   tests_failed = 0;
  vec_t sb_q[$];
  vec_t vecs[9];

  logic        mon_en = 1'b0;
  logic        prev_req = 1'b0;
  int          req_cnt = 0;
  int          stall_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] first_addr = '0;
  logic [31:0] first_wdata = '0;

  mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_read_m_i   (mem_read),
    .mem_write_m_i  (mem_write),
    .alu_out_m_i    (alu_out),
    .write_data_m_i (write_data),
    .req_o          (req),
    .we_o           (we),
    .addr_o         (addr),
    .wdata_o        (wdata),
    .ready_i        (ready),
    .rdata_i        (rdata),
    .read_data_m_o  (read_data),
    .stall_o        (stall),
    .addr_err_o     (addr_err),
    .bus_err_o      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic scoreCompletion();
    vec_t e;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL unexpected_completion: got completion, expected none");
    end else begin
      e = sb_q.pop_front();
      checkOutput("addr_err", 32'(addr_err), 32'(e.exp_addr_err));
      checkOutput("bus_err", 32'(bus_err), 32'(e.exp_bus_err));
      checkOutput("read_data", read_data, e.exp_read_data);
      checkOutput("req_cycles", 32'(req_cnt), 32'(e.exp_req));
      checkOutput("stall_cycles", 32'(stall_cnt), 32'(e.exp_stall));
      checkOutput("we_cycles", 32'(we_cnt), e.wr ? 32'(e.exp_req) : 32'd0);
      if (e.exp_req > 0) begin
        checkOutput("req_addr", first_addr, e.exp_addr);
        if (e.wr) checkOutput("req_wdata", first_wdata, e.wdata);
      end
    end
    req_cnt   = 0;
    stall_cnt = 0;
    we_cnt    = 0;
  endtask

  // Monitor samples on the falling edge, well away from input changes.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall) stall_cnt++;
      if (req) req_cnt++;
      if (we) we_cnt++;
      if (req && !prev_req) begin
        first_addr  = addr;
        first_wdata = wdata;
      end else if (req) begin
        checkOutput("addr_stable", addr, first_addr);
        checkOutput("wdata_stable", wdata, first_wdata);
      end
      if (bus_err && !(prev_req && !req))
        checkOutput("bus_err_spurious", 32'(bus_err), 32'd0);
      if (prev_req && !req) scoreCompletion();
      else if (addr_err) scoreCompletion();
      prev_req = req;
    end else begin
      prev_req  = 1'b0;
      req_cnt   = 0;
      stall_cnt = 0;
      we_cnt    = 0;
    end
  end

  task automatic applyStimulus(input vec_t v);
    int n;
    if (v.exp_addr_err) n = 1;
    else if (v.waits < 0) n = TO + 2;
    else n = v.waits + 3;
    sb_q.push_back(v);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #2;
      if (c == 0) begin
        mem_read   = v.rd;
        mem_write  = v.wr;
        alu_out    = v.addr;
        write_data = v.wdata;
        rdata      = v.rdata;
      end
      ready = (v.waits >= 0) && (c == v.waits + 1);
    end
  endtask

  task automatic idleBus();
    @(posedge clk);
    #2;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_out    = '0;
    write_data = '0;
    ready      = 1'b0;
    rdata      = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t b0, b1, post;
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 0,
                1'b0, 1'b0, 32'hCAFE_BABE, 1, 2, 32'h0000_0100};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0024, 32'h1234_5678, 32'h0, 3,
                1'b0, 1'b0, 32'hCAFE_BABE, 4, 5, 32'h0000_0024};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_0000, 0,
                1'b1, 1'b0, 32'hCAFE_BABE, 0, 0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h1357_2468, -1,
                1'b0, 1'b1, 32'h0, 4, 5, 32'h0000_0200};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h55AA_1234, 1,
                1'b0, 1'b0, 32'h55AA_1234, 2, 3, 32'h0000_0008};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 0,
                1'b0, 1'b0, 32'h55AA_1234, 1, 2, 32'h0000_0030};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_0033, 32'h0F0F_0F0F, 32'h0, 0,
                1'b1, 1'b0, 32'h55AA_1234, 0, 0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0BAD_F00D, 2,
                1'b0, 1'b0, 32'h0BAD_F00D, 3, 4, 32'hFFFF_FFFC};
    vecs[8] = '{1'b0, 1'b1, 32'h0000_0040, 32'h9999_0000, 32'h0, -1,
                1'b0, 1'b1, 32'h0, 4, 5, 32'h0000_0040};
    b0   = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 0,
             1'b0, 1'b0, 32'h1111_1111, 1, 2, 32'h0};
    b1   = '{1'b1, 1'b0, 32'h4, 32'h0, 32'h2222_2222, 0,
             1'b0, 1'b0, 32'h2222_2222, 1, 2, 32'h4};
    post = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h600D_F00D, 2,
             1'b0, 1'b0, 32'h600D_F00D, 3, 4, 32'h0000_0080};

    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_out = '0;
    write_data = '0; ready = 1'b0; rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_req", 32'(req), 32'd0);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_addr", addr, 32'd0);
    checkOutput("reset_wdata", wdata, 32'd0);
    checkOutput("reset_read_data", read_data, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_errs", {30'd0, addr_err, bus_err}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      idleBus();
    end

    // Back-to-back loads with no idle gap in between.
    applyStimulus(b0);
    applyStimulus(b1);
    idleBus();

    // ready_i outside WAIT must not disturb anything.
    @(posedge clk);
    #2;
    ready = 1'b1;
    rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checkOutput("idle_ready_req", 32'(req), 32'd0);
    checkOutput("idle_ready_read_data", read_data, 32'h2222_2222);
    idleBus();

    // Reset asserted in the second WAIT cycle of a load.
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    mem_read = 1'b1;
    alu_out  = 32'h0000_0044;
    rdata    = 32'h7777_7777;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    checkOutput("midwait_req_before", 32'(req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midwait_req", 32'(req), 32'd0);
    checkOutput("midwait_stall", 32'(stall), 32'd0);
    checkOutput("midwait_read_data", read_data, 32'd0);
    checkOutput("midwait_addr", addr, 32'd0);
    mem_read = 1'b0;
    alu_out  = '0;
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    applyStimulus(post);
    idleBus();

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory access controller directly upstream of the memory/writeback pipeline register stage.
- Converts the M-stage load/store control into a request/ready handshake toward the data cache/memory.
- Stalls the pipeline until the access completes.
- Presents the captured load word as read_data_m_o, which feeds the memory stage's read-data input.

Parameters:
- ADDR_WIDTH, 32, width of addr_o and alu_out_m_i.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT, 64, maximum WAIT cycles before a bus error. 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_read_m_i  in  1  M-stage instruction is a load.
- mem_write_m_i  in  1  M-stage instruction is a store.
- alu_out_m_i  in  ADDR_WIDTH  effective byte address.
- write_data_m_i  in  DATA_WIDTH  store data.
- req_o  out  1  memory request valid.
- we_o  out  1  request is a write.
- addr_o  out  ADDR_WIDTH  word-aligned request address.
- wdata_o  out  DATA_WIDTH  request write data.
- ready_i  in  1  memory completes the current request this cycle.
- rdata_i  in  DATA_WIDTH  read data, valid when ready_i=1 and we_o=0.
- read_data_m_o  out  DATA_WIDTH  last captured load data, to the memory stage.
- stall_o  out  1  freeze the F/D/E/M pipeline registers.
- addr_err_o  out  1  one-cycle pulse: misaligned access rejected.
- bus_err_o  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE; req_o=0, we_o=0, addr_o=0, wdata_o=0.
  - read_data_m_o=0, errors=0, timeout counter=0.
  - Takes effect immediately, including mid-WAIT: the request drops and is abandoned with no completion.
- access = mem_read_m_i | mem_write_m_i. If both are set, the access is a write; no read data is captured.
- States: IDLE, WAIT, DONE.
- IDLE:
  - stall_o = access & aligned (combinational). aligned = (alu_out_m_i[1:0]==0).
  - access & aligned: latch addr_o={alu_out_m_i[ADDR_WIDTH-1:2],2'b00}, wdata_o, we_o; go to WAIT.
  - access & misaligned: no request, stall_o=0, addr_err_o=1 next cycle for one cycle, stay in IDLE.
- WAIT:
  - req_o=1 and stall_o=1. addr_o, we_o and wdata_o are held stable until ready_i.
  - ready_i=1: if a read, read_data_m_o<=rdata_i; go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 (TIMEOUT>0) and ready_i=0: read_data_m_o<=0, bus_err_o pulses in the DONE cycle, go to DONE.
  - ready_i and the timeout in the same cycle: ready_i wins, no error.
- DONE:
  - req_o=0, stall_o=0; the pipeline advances one instruction.
  - Unconditionally return to IDLE; the next instruction's access is evaluated there, never in DONE, so an access is never reissued.
  - Counter clears to 0.
- Latency: minimum 3 cycles per access (IDLE detect, WAIT with immediate ready, DONE). N wait cycles give N+2.
- ready_i outside WAIT is ignored.
- read_data_m_o holds its value across stores and non-memory instructions.
- Register outputs: req_o=(state==WAIT); addr_o/wdata_o/we_o from registers. Only stall_o has a combinational path from inputs.
- Counter width is $clog2(TIMEOUT+1). It does not wrap: it saturates at the trigger.

Test Plan:
- Load hit: mem_read=1, addr=0x100, ready_i=1 in the first WAIT cycle, rdata_i=0xCAFEBABE -> stall_o high for 2 cycles; addr_o=0x100, we_o=0; read_data_m_o=0xCAFEBABE in DONE; req_o high exactly 1 cycle.
- Store with 3 wait cycles: mem_write=1, addr=0x24, data=0x12345678 -> req_o/we_o high 4 cycles with addr/wdata stable; stall_o high 5 cycles; read_data_m_o unchanged.
- Misaligned load at addr 0x102 -> req_o never asserts; stall_o=0; addr_err_o one-cycle pulse; state stays IDLE.
- Timeout with TIMEOUT=4, ready_i held 0 -> req_o high 4 cycles; bus_err_o pulses once; read_data_m_o=0; back to IDLE.
- Reset mid-WAIT: rst_ni low during cycle 2 of WAIT -> req_o and stall_o 0 immediately; read_data_m_o=0. After release, a new load completes normally.
- Back-to-back loads to 0x0 then 0x4, ready_i=1 on each first WAIT cycle -> two distinct requests; 6 cycles total; the same address is never issued twice.
